// File: rtl/cmult_rr_sched_pkg.sv
// cmult_sched_pkg: shared width helper and default pipeline stage type for cmult_rr_sched
package cmult_sched_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int NREQ_DEF = 4;
  function automatic int id_w(input int n);
    return $clog2(n) > 1 ? $clog2(n) : 1;
  endfunction
  typedef struct packed {
    logic valid;
    logic [id_w(NREQ_DEF)-1:0] id;
    logic [DATA_W_DEF-1:0] a_real, a_img, b_real, b_img;
  } stage_t;
endpackage

// File: rtl/cmult_rr_sched_if.sv
// cmult_rr_sched_if: requester handshakes and tagged result stream of the shared complex multiplier
interface cmult_rr_sched_if #(
  parameter int DATA_W = 32,
  parameter int NREQ = 4
) ();
  import cmult_sched_pkg::*;
  localparam int IW = id_w(NREQ);
  logic [NREQ-1:0] req_valid, req_ready;
  logic [NREQ*DATA_W-1:0] req_a_real, req_a_img, req_b_real, req_b_img;
  logic res_valid, res_ready, busy;
  logic [IW-1:0] res_id;
  logic [2*DATA_W-1:0] res_real, res_img;
  modport master (
    output req_valid, req_a_real, req_a_img, req_b_real, req_b_img, res_ready,
    input req_ready, res_valid, res_id, res_real, res_img, busy
  );
  modport slave (
    input req_valid, req_a_real, req_a_img, req_b_real, req_b_img, res_ready,
    output req_ready, res_valid, res_id, res_real, res_img, busy
  );
endinterface

// File: rtl/cmult_rr_sched_arb.sv
// rr_arbiter: combinational round-robin grant starting just after the last granted index
module rr_arbiter import cmult_sched_pkg::*; #(
  parameter int NREQ = 4,
  parameter int IW = id_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx
);
  logic [IW-1:0] j;
  always_comb begin
    idx = '0;
    grant = '0;
    j = '0;
    for (int k = NREQ; k >= 1; k--) begin
      j = IW'((int'(last) + k) % NREQ);
      if (req[j]) begin
        idx = j;
        grant = '0;
        grant[j] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/cmult_rr_sched_mult.sv
// cmultipliertrunc: unsigned complex multiply, products truncated to 2*DATA_W bits
module cmultipliertrunc #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]   a_real,
  input  logic [DATA_W-1:0]   a_img,
  input  logic [DATA_W-1:0]   b_real,
  input  logic [DATA_W-1:0]   b_img,
  output logic [2*DATA_W-1:0] res_real,
  output logic [2*DATA_W-1:0] res_img
);
  localparam int PW = 2 * DATA_W;
  assign res_real = PW'(a_real) * PW'(b_real) - PW'(a_img) * PW'(b_img);
  assign res_img = PW'(a_real) * PW'(b_img) + PW'(b_real) * PW'(a_img);
endmodule

// File: rtl/cmult_rr_sched.sv
// cmult_rr_sched: round-robin sharing of one pipelined complex multiplier with a tagged result stream
module cmult_rr_sched import cmult_sched_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int NREQ = 4,
  parameter int LAT = 2
) (
  input logic clk,
  input logic rst,
  cmult_rr_sched_if.slave bus
);
  localparam int IW = id_w(NREQ);
  localparam int PW = 2 * DATA_W;
  typedef struct packed {
    logic valid;
    logic [IW-1:0] id;
    logic [DATA_W-1:0] a_real, a_img, b_real, b_img;
  } op_t;
  typedef struct packed {
    logic valid;
    logic [IW-1:0] id;
    logic [PW-1:0] re, im;
  } prod_t;
  op_t s1;
  prod_t prod, out;
  logic [PW-1:0] p_re, p_im;
  logic [IW-1:0] last, gidx;
  logic [NREQ-1:0] grant;
  logic adv;
  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req(bus.req_valid), .last(last), .grant(grant), .idx(gidx)
  );
  cmultipliertrunc #(.DATA_W(DATA_W)) u_mult (
    .a_real(s1.a_real), .a_img(s1.a_img), .b_real(s1.b_real), .b_img(s1.b_img),
    .res_real(p_re), .res_img(p_im)
  );
  assign adv = !(bus.res_valid && !bus.res_ready);
  assign bus.req_ready = rst ? '0 : grant & {NREQ{adv}};
  assign prod = {s1.valid, s1.id, p_re, p_im};
  always_ff @(posedge clk)
    if (rst) begin
      s1 <= '0;
      last <= IW'(NREQ - 1);
    end else if (adv) begin
      s1 <= {|bus.req_valid, gidx,
             bus.req_a_real[int'(gidx)*DATA_W +: DATA_W], bus.req_a_img[int'(gidx)*DATA_W +: DATA_W],
             bus.req_b_real[int'(gidx)*DATA_W +: DATA_W], bus.req_b_img[int'(gidx)*DATA_W +: DATA_W]};
      if (|bus.req_valid) last <= gidx;
    end
  if (LAT == 1) begin : g_comb
    assign out = prod;
    assign bus.busy = s1.valid;
  end else begin : g_pipe
    prod_t pipe [LAT-1];
    logic pb;
    always_ff @(posedge clk)
      if (rst) begin
        for (int k = 0; k < LAT - 1; k++) pipe[k] <= '0;
      end else if (adv) begin
        pipe[0] <= prod;
        for (int k = 1; k < LAT - 1; k++) pipe[k] <= pipe[k-1];
      end
    always_comb begin
      pb = s1.valid;
      for (int k = 0; k < LAT - 1; k++) pb = pb | pipe[k].valid;
    end
    assign out = pipe[LAT-2];
    assign bus.busy = pb;
  end
  assign bus.res_valid = out.valid;
  assign bus.res_id = out.id;
  assign bus.res_real = out.re;
  assign bus.res_img = out.im;
endmodule

// File: tb/tb_cmult_rr_sched.sv
// tb_cmult_rr_sched: directed stimulus checked against a scoreboard model of the shared multiplier
module tb_cmult_rr_sched;
  localparam int DW = 32, N = 4, L = 2;
  typedef struct {
    int id;
    logic [63:0] re, im;
    int rem;
  } ent_t;
  logic clk = 1'b0, rst = 1'b1;
  int checks = 0, errors = 0;
  int cnt[N], seq[N];
  logic [DW-1:0] ar[N], ai[N], br[N], bi[N];
  bit autold;
  logic [N-1:0] acc = '0;
  int glog[$], rlog[$];
  ent_t q[$];
  int m_last;
  always #5 clk = ~clk;
  cmult_rr_sched_if #(.DATA_W(DW), .NREQ(N)) bus ();
  cmult_rr_sched #(.DATA_W(DW), .NREQ(N), .LAT(L)) dut (.clk(clk), .rst(rst), .bus(bus));
  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
    end
  endfunction
  function automatic logic [63:0] cre(logic [31:0] a_r, a_i, b_r, b_i);
    return {32'b0, a_r} * {32'b0, b_r} - {32'b0, a_i} * {32'b0, b_i};
  endfunction
  function automatic logic [63:0] cim(logic [31:0] a_r, a_i, b_r, b_i);
    return {32'b0, a_r} * {32'b0, b_i} + {32'b0, b_r} * {32'b0, a_i};
  endfunction
  function automatic void load(int i);
    ar[i] = 32'h9E3779B9 * 32'(seq[i] + 1) + 32'(i);
    ai[i] = 32'h85EBCA6B ^ 32'(seq[i] * 977 + i);
    br[i] = 32'hC2B2AE35 + 32'(seq[i] * 40503);
    bi[i] = 32'h27D4EB2F * 32'(i + 1) - 32'(seq[i]);
  endfunction
  function automatic int pending();
    int s = 0;
    for (int i = 0; i < N; i++) s += cnt[i];
    return s;
  endfunction
  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i] = cnt[i] > 0;
      bus.req_a_real[i*DW +: DW] = ar[i];
      bus.req_a_img[i*DW +: DW] = ai[i];
      bus.req_b_real[i*DW +: DW] = br[i];
      bus.req_b_img[i*DW +: DW] = bi[i];
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (acc[i]) begin
        cnt[i]--;
        seq[i]++;
        if (autold) load(i);
      end
    drive();
  endtask
  task automatic drain(string name);
    int n = 0;
    while ((pending() > 0 || bus.busy) && n < 100) begin
      step();
      n++;
    end
    chk(name, 64'(n < 100), 64'(1));
  endtask
  always @(negedge clk) begin
    logic [N-1:0] er;
    logic [N-1:0] hs;
    bit ev, adv_m;
    int g, j;
    ent_t e;
    hs = bus.req_valid & bus.req_ready;
    acc = '0;
    if (rst) begin
      q.delete();
      m_last = N - 1;
      chk("rst_ready", 64'(bus.req_ready), 64'(0));
    end else begin
      ev = q.size() > 0 && q[0].rem == 0;
      adv_m = !(ev && !bus.res_ready);
      g = -1;
      if (adv_m)
        for (int k = 1; k <= N; k++) begin
          j = (m_last + k) % N;
          if (g < 0 && bus.req_valid[j]) g = j;
        end
      er = g >= 0 ? N'(1) << g : '0;
      chk("req_ready", 64'(bus.req_ready), 64'(er));
      chk("res_valid", 64'(bus.res_valid), 64'(ev));
      chk("busy", 64'(bus.busy), 64'(q.size() > 0));
      if (ev) begin
        chk("res_id", 64'(bus.res_id), 64'(q[0].id));
        chk("res_real", bus.res_real, q[0].re);
        chk("res_img", bus.res_img, q[0].im);
      end
      for (int k = 0; k < N; k++) if (hs[k]) glog.push_back(k);
      if (bus.res_valid && bus.res_ready) rlog.push_back(int'(bus.res_id));
      if (ev && bus.res_ready) void'(q.pop_front());
      if (adv_m) foreach (q[k]) if (q[k].rem > 0) q[k].rem = q[k].rem - 1;
      if (g >= 0) begin
        e.id = g;
        e.re = cre(bus.req_a_real[g*DW +: DW], bus.req_a_img[g*DW +: DW],
                   bus.req_b_real[g*DW +: DW], bus.req_b_img[g*DW +: DW]);
        e.im = cim(bus.req_a_real[g*DW +: DW], bus.req_a_img[g*DW +: DW],
                   bus.req_b_real[g*DW +: DW], bus.req_b_img[g*DW +: DW]);
        e.rem = L - 1;
        q.push_back(e);
        m_last = g;
      end
      acc = hs;
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end
  initial begin
    logic [63:0] sre, sim;
    logic [1:0] sid;
    int exp_s[6];
    exp_s = '{1, 3, 1, 3, 1, 3};
    for (int i = 0; i < N; i++) begin
      cnt[i] = 0; seq[i] = 0; ar[i] = '0; ai[i] = '0; br[i] = '0; bi[i] = '0;
    end
    autold = 1'b0;
    bus.res_ready = 1'b1;
    drive();
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_res_valid", 64'(bus.res_valid), 64'(0));
    chk("rst_res_real", bus.res_real, 64'(0));
    chk("rst_res_img", bus.res_img, 64'(0));
    chk("rst_res_id", 64'(bus.res_id), 64'(0));
    chk("rst_busy", 64'(bus.busy), 64'(0));
    // all four streaming, with a three-edge output stall in the middle
    autold = 1'b1;
    for (int i = 0; i < N; i++) begin load(i); cnt[i] = 3; end
    glog.delete(); rlog.delete();
    step();
    repeat (5) step();
    bus.res_ready = 1'b0;
    @(negedge clk);
    sre = bus.res_real; sim = bus.res_img; sid = bus.res_id;
    chk("stall_ready", 64'(bus.req_ready), 64'(0));
    repeat (2) begin
      step();
      @(negedge clk);
      chk("stall_ready", 64'(bus.req_ready), 64'(0));
      chk("stall_real", bus.res_real, sre);
      chk("stall_img", bus.res_img, sim);
      chk("stall_id", 64'(bus.res_id), 64'(sid));
    end
    step();
    bus.res_ready = 1'b1;
    drain("drain_stream");
    chk("stream_grants", 64'(glog.size()), 64'(12));
    chk("stream_results", 64'(rlog.size()), 64'(12));
    foreach (glog[k]) chk("stream_grant_order", 64'(glog[k]), 64'(k % N));
    foreach (rlog[k]) chk("stream_id_order", 64'(rlog[k]), 64'(k % N));
    // single request from requester 2: 3+2i times 5+4i
    autold = 1'b0;
    ar[2] = 3; ai[2] = 2; br[2] = 5; bi[2] = 4; cnt[2] = 1;
    drive();
    @(negedge clk);
    chk("single_ready", 64'(bus.req_ready), 64'(4'b0100));
    step();
    @(negedge clk);
    chk("single_early", 64'(bus.res_valid), 64'(0));
    step();
    @(negedge clk);
    chk("single_valid", 64'(bus.res_valid), 64'(1));
    chk("single_id", 64'(bus.res_id), 64'(2));
    chk("single_real", bus.res_real, 64'd7);
    chk("single_img", bus.res_img, 64'd22);
    drain("drain_single");
    // modulo wrap of the product
    ar[0] = 32'hFFFFFFFF; ai[0] = 0; br[0] = 32'hFFFFFFFF; bi[0] = 0; cnt[0] = 1;
    drive();
    step();
    step();
    @(negedge clk);
    chk("wrap_valid", 64'(bus.res_valid), 64'(1));
    chk("wrap_real", bus.res_real, 64'hFFFFFFFE00000001);
    chk("wrap_img", bus.res_img, 64'h0);
    drain("drain_wrap");
    // sparse requesters 1 and 3 with idle cycles in between
    autold = 1'b1;
    load(1); load(3); cnt[1] = 2; cnt[3] = 2;
    glog.delete();
    drive();
    drain("drain_sparse_a");
    repeat (3) step();
    cnt[1] = 1; cnt[3] = 1;
    drive();
    drain("drain_sparse_b");
    chk("sparse_grants", 64'(glog.size()), 64'(6));
    foreach (glog[k]) if (k < 6) chk("sparse_order", 64'(glog[k]), 64'(exp_s[k]));
    // reset with two entries in flight
    load(1); load(2); cnt[1] = 3; cnt[2] = 3;
    drive();
    step();
    step();
    rst = 1'b1;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    drive();
    step();
    rst = 1'b0;
    load(0); load(3); cnt[0] = 1; cnt[3] = 1;
    glog.delete(); rlog.delete();
    drive();
    @(negedge clk);
    chk("post_rst_valid", 64'(bus.res_valid), 64'(0));
    chk("post_rst_busy", 64'(bus.busy), 64'(0));
    chk("post_rst_ready", 64'(bus.req_ready), 64'(4'b0001));
    drain("drain_post_rst");
    chk("post_rst_grants", 64'(glog.size()), 64'(2));
    if (glog.size() > 0) chk("post_rst_first", 64'(glog[0]), 64'(0));
    chk("post_rst_results", 64'(rlog.size()), 64'(2));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cmult_rr_sched.md
# cmult_rr_sched

Round-robin scheduler that shares one truncating complex-multiplier datapath, `cmultipliertrunc`, between NREQ requesters in the QFT amplitude-update path. Each requester presents a complex operand pair with a valid/ready handshake. The block grants one requester per cycle, registers the operands and pipelines the product. It returns each result on a single tagged output stream with backpressure.

## Interface
- `DATA_W`, 32, operand width per real/imag component.
- `NREQ`, 4, number of requesters, ≥2.
- `LAT`, 2, cycles from acceptance to result, ≥1. Counts the operand register plus LAT−1 product registers.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `req_valid` in NREQ: requester i has an operand pair.
- `req_ready` out NREQ: requester i accepted this cycle; at most one bit high.
- `req_a_real`, `req_a_img`, `req_b_real`, `req_b_img` in NREQ*DATA_W: packed operands, slice i belongs to requester i.
- `res_valid` out 1: result present.
- `res_ready` in 1: downstream accepts result.
- `res_id` out $clog2(NREQ): index of the originating requester.
- `res_real`, `res_img` out 2*DATA_W: product components.
- `busy` out 1: any pipeline stage holds a valid entry.

## Operation
- Handshake:
  - A transfer occurs when `req_valid[i] && req_ready[i]` at a rising edge.
  - A requester holds its `req_valid` and operands stable until ready is given, and must not derive `req_valid` from `req_ready`.
  - `req_ready` depends combinationally on `req_valid`.
- Arbitration:
  - A round-robin pointer `last` holds the most recently granted index.
  - Priority order is `last+1, last+2, …` modulo NREQ.
  - The grant goes to the first asserting requester in that order.
  - `last` updates only on an actual transfer.
- Pipeline:
  - Stage 1 holds the registered operands plus id and valid.
  - `cmultipliertrunc` sits between stage 1 and stage 2.
  - Stages 2..LAT register the products, id and valid; the last stage drives `res_*`.
  - With LAT=1, the operand register is the output: the multiply is combinational on stage-1 operands.
- Advance: `adv = !(res_valid && !res_ready)`.
  - All stages shift only when `adv` is high; there is a full stall otherwise and bubbles are not collapsed.
  - `req_ready[i] = grant[i] && adv`.
- Arithmetic (unsigned operands, all results modulo 2^(2*DATA_W), carry-out discarded):
  - `res_real = A_real*B_real − A_img*B_img`
  - `res_img = A_real*B_img + B_real*A_img`
- Boundary conditions:
  - No `req_valid` asserted: no grant, `last` unchanged, and a bubble enters when `adv` is high.
  - Stall with all requesters valid: no `req_ready`; operands stay at the requesters.
  - Simultaneous output acceptance and new input: both occur in the same cycle, sustaining one transfer per cycle.
  - Pointer wrap: after granting NREQ−1, requester 0 has highest priority.
  - Reset mid-operation: all in-flight entries are discarded and no result is emitted for them.

## Timing
- Reset values (cycle after the `rst` edge):
  - `res_valid`=0, `res_real`=0, `res_img`=0, `res_id`=0, `busy`=0.
  - All stage valids are 0 and `last`=NREQ−1, so requester 0 has first priority.
  - `req_ready` is forced to 0 while `rst` is high.
- Latency: a transfer at edge k gives `res_valid`=1 after edge k+LAT−1, i.e. LAT cycles after the request cycle, provided there is no stall.
- Throughput: one result per cycle with `res_ready` held high.
- A stall of S cycles adds exactly S cycles to every in-flight entry.
- Output stability: `res_*` are stable while `res_valid && !res_ready`.
- `busy` is the OR of all stage valids, registered-consistent with the stages and with no extra delay.

## Structure
- Package `cmult_sched_pkg` holds:
  - an `ID_W` localparam function, `$clog2(NREQ)` with a minimum of 1;
  - a typedef `stage_t` {valid, id, operand or product fields} parameterised via the package.
- Sub-module `rr_arbiter`: inputs are the request vector and the `last` pointer; outputs are a one-hot grant and the encoded index; purely combinational.
- One `cmultipliertrunc` instance with `DATA_W` passed through; no other arithmetic in this block.

## Test plan
- Single request, DATA_W=32, LAT=2: requester 2 sends A=3+2i, B=5+4i → two cycles later `res_valid`, `res_id`=2, `res_real`=7, `res_img`=22.
- All four requesters valid continuously, `res_ready`=1: grants in order 0,1,2,3,0,… one per cycle; `res_id` sequence matches with LAT offset.
- Wrap modulo: A=0xFFFFFFFF+0i, B=0xFFFFFFFF+0i → `res_real`=0xFFFFFFFE00000001, `res_img`=0.
- Backpressure: drop `res_ready` for 3 cycles during streaming → `req_ready` all 0 for those cycles, `res_*` held stable, no loss or duplication, order preserved.
- Sparse requests: only requesters 1 and 3 valid → alternating grants 1,3,1,3; `last` not advanced in idle cycles.
- Reset with 2 entries in flight → `res_valid` stays 0 after reset and `busy`=0; the next grant goes to requester 0.
